// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM state type and alignment helpers for the LSU.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SZ_B = 2'b00;
    localparam logic [SIZE_W-1:0] SZ_H = 2'b01;
    localparam logic [SIZE_W-1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    // True when the low address bits break natural alignment for the size.
    function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                           input logic [1:0]        lo);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

    // Forces the low address bits to natural alignment for the size.
    function automatic logic [1:0] align_lo(input logic [SIZE_W-1:0] size,
                                            input logic [1:0]        lo);
        logic [1:0] res;
        case (size)
            SZ_B:    res = lo;
            SZ_H:    res = {lo[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks a byte/half lane out of a word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        offset,
    input  logic [SIZE_W-1:0] size,
    input  logic              uns,
    output logic [WORD_W-1:0] data_c
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection followed by extension.
    always_comb begin
        byte_lane = word[7:0];
        half_lane = word[15:0];
        data_c    = word;
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        if (offset[1]) begin
            half_lane = word[31:16];
        end
        case (size)
            SZ_B:    data_c = uns ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            SZ_H:    data_c = uns ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: data_c = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: byte-addressed load/store initiator for a word-organised
// single-port RAM, with read-modify-write for sub-word stores.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned accesses complete with
// rsp_err=1 and no RAM access; otherwise they are force-aligned and proceed.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    state_t                state;
    logic [SIZE_W-1:0]     size_q;
    logic                  uns_q;
    logic [1:0]            lo_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  misalign_c;
    logic [1:0]            lo_c;
    logic [DATA_WIDTH-1:0] load_data_c;
    logic [DATA_WIDTH-1:0] lane_c;
    logic [DATA_WIDTH-1:0] mask_c;
    logic [DATA_WIDTH-1:0] merged_c;
    logic [4:0]            shift_c;
    logic                  unused_addr_bits;

    // Address bits above the RAM word address are intentionally dropped (wrap).
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned requests are flagged and bypass the RAM.
    assign misalign_c = is_misaligned(req_size, req_addr[1:0]);
    assign lo_c       = req_addr[1:0];
`else
    // Misaligned requests are silently aligned down.
    assign misalign_c = 1'b0;
    assign lo_c       = align_lo(req_size, req_addr[1:0]);
`endif

    // Extended load data from the addressed RAM word.
    lsu_load_align u_load_align (
        .word   (mem_RD),
        .offset (lo_q),
        .size   (size_q),
        .uns    (uns_q),
        .data_c (load_data_c)
    );

    // Store lane: the right-justified byte/half of wdata with upper bits cleared.
    lsu_load_align u_lane_align (
        .word   (wdata_q),
        .offset (2'b00),
        .size   (size_q),
        .uns    (1'b1),
        .data_c (lane_c)
    );

    // Merge the store lane into the word read back from RAM.
    always_comb begin
        shift_c  = {lo_q, 3'b000};
        mask_c   = (size_q == SZ_B) ? 32'h0000_00FF : 32'h0000_FFFF;
        merged_c = (mem_RD & ~(mask_c << shift_c)) | (lane_c << shift_c);
    end

    // Write strobe decoded from the state register so reset drops it at once.
    assign mem_we = (state == WRITE);

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_A     <= '0;
            mem_WD    <= '0;
            size_q    <= SZ_B;
            uns_q     <= 1'b0;
            lo_q      <= 2'b00;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        mem_A     <= req_addr[ADDR_WIDTH+1:2];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        lo_q      <= lo_c;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= '0;
                        rsp_err   <= misalign_c;
                        if (misalign_c) begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_size[1]) begin
                            mem_WD <= req_wdata;
                            state  <= WRITE;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= load_data_c;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RMW_RD: begin
                    mem_WD <= merged_c;
                    state  <= WRITE;
                end
                WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
